ram_burst_unpacker: RTL and testbench
=====================================

RAM_BURST_UNPACKER -- requirements
Module: ram_burst_unpacker

Interface
REQ-001 SHALL have parameter W_ADDR, default 12, RAM address width.
REQ-002 SHALL have parameter W_DATA, default 128, RAM word width.
REQ-003 SHALL have parameter W_PW, default 16, pulse-width lane width; W_DATA SHALL be an integer multiple of it (L = W_DATA/W_PW lanes).
REQ-004 SHALL have parameter RD_LATENCY, default 2, RAM read latency in cycles (range 1..4).
REQ-005 SHALL have parameter FIFO_DEPTH, default 32, output FIFO entries (power of 2, at least L*RD_LATENCY).
REQ-006 SHALL have ports, one per line:
clk  in  1  single clock; reset is asynchronous and active-high
rst  in  1  asynchronous active-high reset
start  in  1  one-cycle burst request
base_addr  in  W_ADDR  first RAM address, sampled on accepted start
num_words  in  W_ADDR+1  RAM words to read, sampled on accepted start
rd_addr  out  W_ADDR  RAM port-B address
rden  out  1  RAM port-B read enable
rd_data  in  W_DATA  RAM read data, valid RD_LATENCY cycles after rden
pw_data  out  W_PW  unpacked pulse width
pw_valid  out  1  pw_data valid
pw_ready  in  1  downstream accept
busy  out  1  burst in progress
done  out  1  one-cycle pulse, burst complete

Function
REQ-007 SHALL run FSM IDLE -> READ -> DRAIN -> IDLE; start is accepted only in IDLE.
REQ-008 SHALL, on accepted start, latch base_addr/num_words, enter READ, and assert busy from the next cycle.
REQ-009 SHALL, in READ, issue one rden cycle per word at rd_addr = base+k, k = 0..num_words-1, only when FIFO free entries >= L*(in-flight words + 1).
REQ-010 SHALL wrap rd_addr modulo 2^W_ADDR.
REQ-011 SHALL use a RD_LATENCY-deep valid shift register to capture rd_data exactly RD_LATENCY cycles after each rden.
REQ-012 SHALL split each captured word into L lanes and push them into the FIFO most-significant lane first, one lane per cycle, with no lane lost or reordered.
REQ-013 SHALL go to DRAIN after the last rden, and go to IDLE with a done pulse once the last lane is pushed (FIFO may still hold data).
REQ-014 SHALL, for num_words = 0, issue no reads, pulse done one cycle after start, and return to IDLE.
REQ-015 SHALL present FIFO head on pw_data/pw_valid; a transfer occurs when pw_valid and pw_ready are both high; pw_data is stable while pw_valid is high without pw_ready.
REQ-016 SHALL never overflow the FIFO; backpressure stalls rden only, never captured data.
REQ-017 SHALL support simultaneous FIFO push and pop in one cycle.

Reset
REQ-018 SHALL, on rst, asynchronously clear: FSM to IDLE, rden 0, rd_addr 0, busy 0, done 0, pw_valid 0, FIFO empty, in-flight pipeline cleared.
REQ-019 SHALL discard any burst interrupted by rst; read data returning after reset release is ignored.

Configuration
REQ-020 SHALL honour macro PW_ZERO_SKIP_EN: when defined, lanes equal to zero are not pushed (credit accounting unchanged, done timing per REQ-013); when undefined, all lanes are pushed.

Structure
REQ-021 SHALL place the FSM state enum, the lane-count function and default parameter constants in shared package pcie_dma_pkg.
REQ-022 SHALL instantiate a single sub-module burst_fifo (synchronous FIFO with count output) for pulse-width buffering.

Verification
REQ-023 Bench: RAM addr0..3 preloaded, start base=0 num=4, pw_ready=1 -> 32 lanes out, MS lane of addr0 first, done once, 4 rden cycles.
REQ-024 Bench: pw_ready=0 during burst of 8 words, FIFO_DEPTH=32 -> rden stalls with FIFO at most 32 entries, no loss; then ready=1 -> all 64 lanes in order.
REQ-025 Bench: base=0xFFE num=4 -> rd_addr sequence FFE, FFF, 000, 001.
REQ-026 Bench: num=0 -> no rden, done one cycle after start, busy low.
REQ-027 Bench: rst asserted mid-READ -> outputs cleared immediately; new start base=5 num=1 -> exactly the 8 lanes of addr5.
REQ-028 Bench: PW_ZERO_SKIP_EN defined, word with 3 zero lanes -> 5 lanes out, order preserved.

Source files
------------

// File: rtl/pcie_dma_pkg.sv
// Shared types and defaults for the RAM burst unpacker: FSM states,
// lane-count helper and default parameter values.
package pcie_dma_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2
  } burst_state_e;

  localparam int DEF_W_ADDR     = 12;
  localparam int DEF_W_DATA     = 128;
  localparam int DEF_W_PW       = 16;
  localparam int DEF_RD_LATENCY = 2;
  localparam int DEF_FIFO_DEPTH = 32;

  // Captured RAM words awaiting unpack; also caps words in flight.
  localparam int WQ_DEPTH = 4;

  function automatic int lane_count(input int w_data, input int w_pw);
    return w_data / w_pw;
  endfunction

endpackage

// File: rtl/ram_burst_unpacker_burst_fifo.sv
// Synchronous show-ahead FIFO with occupancy count; push and pop may
// happen in the same cycle.
module burst_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  always_comb begin
    do_push = push && (cnt_q != CW'(DEPTH));
    do_pop  = pop && (cnt_q != '0);
    wr_d    = wr_q + AW'(do_push);
    rd_d    = rd_q + AW'(do_pop);
    cnt_d   = cnt_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end

  assign dout  = mem_q[rd_q];
  assign empty = (cnt_q == '0);
  assign count = cnt_q;

endmodule

// File: rtl/ram_burst_unpacker.sv
// Reads a burst of RAM words and unpacks each into W_PW lanes (MS lane first)
// into an output FIFO. Macro PW_ZERO_SKIP_EN drops all-zero lanes.
module ram_burst_unpacker
  import pcie_dma_pkg::*;
#(
  parameter int W_ADDR     = DEF_W_ADDR,
  parameter int W_DATA     = DEF_W_DATA,
  parameter int W_PW       = DEF_W_PW,
  parameter int RD_LATENCY = DEF_RD_LATENCY,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [W_ADDR-1:0] base_addr,
  input  logic [W_ADDR:0]   num_words,
  output logic [W_ADDR-1:0] rd_addr,
  output logic              rden,
  input  logic [W_DATA-1:0] rd_data,
  output logic [W_PW-1:0]   pw_data,
  output logic              pw_valid,
  input  logic              pw_ready,
  output logic              busy,
  output logic              done
);
  localparam int L   = lane_count(W_DATA, W_PW);
  localparam int LW  = (L > 1) ? $clog2(L) : 1;
  localparam int FCW = $clog2(FIFO_DEPTH) + 1;
  localparam int IW  = $clog2(WQ_DEPTH + 1);
  localparam int QW  = $clog2(WQ_DEPTH);
  localparam logic [W_ADDR:0] ONE_WORD = 1;

  burst_state_e          state_q, state_d;
  logic [W_ADDR-1:0]     next_addr_q, next_addr_d, rd_addr_q, rd_addr_d;
  logic [W_ADDR:0]       left_q, left_d;
  logic                  rden_q, rden_d, done_q, done_d;
  logic [IW-1:0]         inflight_q, inflight_d;
  logic [RD_LATENCY-1:0] vld_pipe_q, vld_pipe_d;
  logic [W_DATA-1:0]     wq_mem_q [WQ_DEPTH];
  logic [QW-1:0]         wq_wr_q, wq_wr_d, wq_rd_q, wq_rd_d;
  logic [IW-1:0]         wq_cnt_q, wq_cnt_d;
  logic [LW-1:0]         lane_q, lane_d;

  logic [W_DATA-1:0]     head;
  logic [W_PW-1:0]       lane_val;
  logic                  capture, unpack, retire, push, pop, issue_ok;
  logic [FCW-1:0]        fifo_cnt;
  logic                  fifo_empty;

  assign capture  = vld_pipe_q[RD_LATENCY-1];
  assign unpack   = (wq_cnt_q != '0);
  assign retire   = unpack && (lane_q == LW'(L - 1));
  assign head     = wq_mem_q[wq_rd_q];
  assign lane_val = W_PW'(head >> (W_DATA - W_PW * (int'(lane_q) + 1)));
  assign pop      = pw_valid && pw_ready;

  // Reserve a full word of FIFO space for every word not yet fully unpacked.
  assign issue_ok = (inflight_q < IW'(WQ_DEPTH)) &&
                    ((FIFO_DEPTH - int'(fifo_cnt)) >= L * (int'(inflight_q) + 1));

`ifdef PW_ZERO_SKIP_EN
  assign push = unpack && (lane_val != '0);
`else
  assign push = unpack;
`endif

  always_comb begin
    state_d     = state_q;
    next_addr_d = next_addr_q;
    rd_addr_d   = rd_addr_q;
    left_d      = left_q;
    rden_d      = 1'b0;
    done_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (num_words == '0) begin
            done_d = 1'b1;
          end else begin
            state_d     = S_READ;
            next_addr_d = base_addr;
            left_d      = num_words;
          end
        end
      end
      S_READ: begin
        if (issue_ok) begin
          rden_d      = 1'b1;
          rd_addr_d   = next_addr_q;
          next_addr_d = next_addr_q + 1'b1;
          left_d      = left_q - 1'b1;
          if (left_q == ONE_WORD) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (retire && (inflight_q == IW'(1))) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    vld_pipe_d = RD_LATENCY'({vld_pipe_q, rden_q});
    inflight_d = inflight_q + IW'(rden_d) - IW'(retire);
    wq_wr_d    = wq_wr_q + QW'(capture);
    wq_rd_d    = wq_rd_q + QW'(retire);
    wq_cnt_d   = wq_cnt_q + IW'(capture) - IW'(retire);
    lane_d     = lane_q;
    if (unpack) lane_d = retire ? '0 : lane_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      next_addr_q <= '0;
      rd_addr_q   <= '0;
      left_q      <= '0;
      rden_q      <= 1'b0;
      done_q      <= 1'b0;
      inflight_q  <= '0;
      vld_pipe_q  <= '0;
      wq_wr_q     <= '0;
      wq_rd_q     <= '0;
      wq_cnt_q    <= '0;
      lane_q      <= '0;
    end else begin
      state_q     <= state_d;
      next_addr_q <= next_addr_d;
      rd_addr_q   <= rd_addr_d;
      left_q      <= left_d;
      rden_q      <= rden_d;
      done_q      <= done_d;
      inflight_q  <= inflight_d;
      vld_pipe_q  <= vld_pipe_d;
      wq_wr_q     <= wq_wr_d;
      wq_rd_q     <= wq_rd_d;
      wq_cnt_q    <= wq_cnt_d;
      lane_q      <= lane_d;
    end
  end

  always_ff @(posedge clk) begin
    if (capture) wq_mem_q[wq_wr_q] <= rd_data;
  end

  burst_fifo #(.W(W_PW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (lane_val),
    .pop   (pop),
    .dout  (pw_data),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  assign rd_addr  = rd_addr_q;
  assign rden     = rden_q;
  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign pw_valid = !fifo_empty;

endmodule

// File: tb/tb_ram_burst_unpacker.sv
// Directed bench for ram_burst_unpacker: table of bursts plus hand-written
// num=0, mid-burst reset and zero-lane sequences.
module tb_ram_burst_unpacker;
  localparam int W_ADDR = 12, W_DATA = 128, W_PW = 16, RD_LATENCY = 2, FIFO_DEPTH = 32;
  localparam int L = 8;

  logic              clk = 1'b0;
  logic              rst, start, pw_ready;
  logic [W_ADDR-1:0] base_addr, rd_addr;
  logic [W_ADDR:0]   num_words;
  logic              rden, pw_valid, busy, done;
  logic [W_DATA-1:0] rd_data;
  logic [W_PW-1:0]   pw_data;

  always #5 clk = ~clk;

  ram_burst_unpacker #(
    .W_ADDR(W_ADDR), .W_DATA(W_DATA), .W_PW(W_PW),
    .RD_LATENCY(RD_LATENCY), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .num_words(num_words), .rd_addr(rd_addr), .rden(rden), .rd_data(rd_data),
    .pw_data(pw_data), .pw_valid(pw_valid), .pw_ready(pw_ready),
    .busy(busy), .done(done)
  );

  // RAM model with two-cycle read latency
  logic [W_DATA-1:0] mem [4096];
  logic [W_ADDR-1:0] ap0, ap1;
  always @(posedge clk) begin
    ap0 <= rd_addr;
    ap1 <= ap0;
  end
  assign rd_data = mem[ap1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [W_PW-1:0]   got_q[$];
  logic [W_PW-1:0]   exp_q[$];
  logic [W_ADDR-1:0] addr_q[$];
  int rden_cnt, done_cnt, start_cyc, done_cyc, busy_cyc;
  logic clr = 1'b0;

  always @(negedge clk) begin
    if (clr) begin
      got_q.delete();
      addr_q.delete();
      rden_cnt = 0; done_cnt = 0;
      start_cyc = -1; done_cyc = -1; busy_cyc = -1;
    end else if (!rst) begin
      if (pw_valid && pw_ready) got_q.push_back(pw_data);
      if (rden) begin rden_cnt++; addr_q.push_back(rd_addr); end
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (start) start_cyc = cyc;
      if (busy && busy_cyc < 0) busy_cyc = cyc;
    end
  end

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string name, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_mon();
    clr = 1'b1;
    @(negedge clk); #1;
    clr = 1'b0;
  endtask

  function automatic logic [W_PW-1:0] exp_lane(input int a, input int j);
    logic [11:0] a12;
    logic [3:0]  j4;
    a12 = 12'(a);
    j4  = 4'(j + 1);
    return {a12, j4};
  endfunction

  task automatic fill_exp(input int base, input int num);
    exp_q.delete();
    for (int k = 0; k < num; k++)
      for (int j = 0; j < L; j++) exp_q.push_back(exp_lane(base + k, j));
  endtask

  typedef struct {
    int base;
    int num;
    int stall;
    int exp_stall_rden;
    int exp_rden;
    int exp_lanes;
  } vec_t;

  task automatic run_burst(input string tag, input vec_t v);
    int nerr, aerr, n;
    bit fin;
    clear_mon();
    tick();
    base_addr = 12'(v.base);
    num_words = 13'(v.num);
    pw_ready  = (v.stall == 0);
    start     = 1'b1;
    tick();
    start     = 1'b0;
    if (v.stall > 0) begin
      repeat (v.stall) tick();
      chk({tag, "_stall_rden"}, rden_cnt, v.exp_stall_rden);
      pw_ready = 1'b1;
    end
    fin = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      tick();
      if (done_cnt > 0 && !pw_valid) begin fin = 1'b1; break; end
    end
    chk({tag, "_finish"}, fin, 1);
    chk({tag, "_rden"}, rden_cnt, v.exp_rden);
    chk({tag, "_lanes"}, got_q.size(), v.exp_lanes);
    nerr = 0;
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) if (got_q[i] != exp_q[i]) nerr++;
    chk({tag, "_order_errs"}, nerr, 0);
    aerr = 0;
    for (int k = 0; k < addr_q.size(); k++) if (addr_q[k] != 12'(v.base + k)) aerr++;
    chk({tag, "_addr_errs"}, aerr, 0);
    chk({tag, "_done_cnt"}, done_cnt, 1);
    chk({tag, "_busy_delay"}, busy_cyc - start_cyc, 1);
  endtask

  vec_t vecs[5];

  initial begin
    vecs[0] = '{base: 'h000, num: 4, stall: 0,  exp_stall_rden: 0, exp_rden: 4, exp_lanes: 32};
    vecs[1] = '{base: 'h100, num: 8, stall: 60, exp_stall_rden: 4, exp_rden: 8, exp_lanes: 64};
    vecs[2] = '{base: 'hFFE, num: 4, stall: 0,  exp_stall_rden: 0, exp_rden: 4, exp_lanes: 32};
    vecs[3] = '{base: 'h007, num: 1, stall: 5,  exp_stall_rden: 1, exp_rden: 1, exp_lanes: 8};
    vecs[4] = '{base: 'h020, num: 3, stall: 0,  exp_stall_rden: 0, exp_rden: 3, exp_lanes: 24};

    for (int a = 0; a < 4096; a++)
      for (int j = 0; j < L; j++) mem[a][W_DATA-1-W_PW*j -: W_PW] = exp_lane(a, j);

    rst = 1'b0; start = 1'b0; base_addr = '0; num_words = '0; pw_ready = 1'b1;
    #2 rst = 1'b1;
    repeat (3) tick();
    chk("rst_rden", rden, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pw_valid", pw_valid, 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 5; i++) begin
      fill_exp(vecs[i].base, vecs[i].num);
      run_burst($sformatf("v%0d", i), vecs[i]);
    end

    // zero-length burst
    clear_mon();
    tick();
    base_addr = 12'h055; num_words = '0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    chk("zero_rden", rden_cnt, 0);
    chk("zero_done_cnt", done_cnt, 1);
    chk("zero_done_delay", done_cyc - start_cyc, 1);
    chk("zero_busy_seen", busy_cyc, -1);

    // reset in the middle of a read burst
    clear_mon();
    tick();
    base_addr = 12'h010; num_words = 13'd8; pw_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    #1;
    chk("mid_rst_rden", rden, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_pw_valid", pw_valid, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_rd_addr", rd_addr, 0);
    tick(); tick();
    rst = 1'b0;
    fill_exp(5, 1);
    run_burst("post_rst", '{base: 5, num: 1, stall: 0, exp_stall_rden: 0, exp_rden: 1, exp_lanes: 8});

    // word with three zero lanes
    mem[12'h040][W_DATA-1-W_PW*1 -: W_PW] = '0;
    mem[12'h040][W_DATA-1-W_PW*4 -: W_PW] = '0;
    mem[12'h040][W_DATA-1-W_PW*6 -: W_PW] = '0;
    exp_q.delete();
    for (int j = 0; j < L; j++) begin
`ifdef PW_ZERO_SKIP_EN
      if (j != 1 && j != 4 && j != 6) exp_q.push_back(exp_lane('h40, j));
`else
      exp_q.push_back((j == 1 || j == 4 || j == 6) ? 16'h0000 : exp_lane('h40, j));
`endif
    end
`ifdef PW_ZERO_SKIP_EN
    run_burst("zskip", '{base: 'h40, num: 1, stall: 0, exp_stall_rden: 0, exp_rden: 1, exp_lanes: 5});
`else
    run_burst("zkeep", '{base: 'h40, num: 1, stall: 0, exp_stall_rden: 0, exp_rden: 1, exp_lanes: 8});
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
